// File: rtl/defines.sv
// Shared EX-stage definitions: divider FSM state codes, iteration counter width
// and the ALU op codes that select DIV/DIVU.
package defines;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_RUN    = 2'd2,
    DIV_DONE   = 2'd3
  } div_state_e;

  localparam int DIV_CNT_W = 5;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_ctrl_if.sv
// Request/result bundle between the EX stage (master) and the divider sequencer (slave).
interface div_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              signed_div;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              annul;
  logic [DATA_W-1:0] result_hi;
  logic [DATA_W-1:0] result_lo;
  logic              ready;
  logic              busy;
  logic              stall_req;

  modport master (
    output start, signed_div, dividend, divisor, annul,
    input  result_hi, result_lo, ready, busy, stall_req
  );

  modport slave (
    input  start, signed_div, dividend, divisor, annul,
    output result_hi, result_lo, ready, busy, stall_req
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dvd_bit_i,
  input  logic [DATA_W-1:0] dsr_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem_i < dsr_i always holds, so the trial difference fits in DATA_W+1 bits
  // and its MSB is a reliable borrow flag.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted - {1'b0, dsr_i};
    q_o     = ~diff[DATA_W];
    rem_o   = q_o ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: latches operand magnitudes, runs 32 restoring
// steps (one per cycle), sign-corrects and presents a registered one-cycle ready.
module div_ctrl
  import defines::*;
#(
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  div_ctrl_if.slave bus
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DATA_W - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 sgn_q, sgn_d;
  logic                 dvd_neg_q, dvd_neg_d;
  logic                 dsr_neg_q, dsr_neg_d;
  logic [DATA_W-1:0]    dvd_q, dvd_d;
  logic [DATA_W-1:0]    dsr_q, dsr_d;
  logic [DATA_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]    quo_q, quo_d;
  logic [DATA_W-1:0]    hi_q, hi_d;
  logic [DATA_W-1:0]    lo_q, lo_d;
  logic                 ready_q, ready_d;

  logic [DATA_W-1:0]    step_rem;
  logic                 step_bit;

  // Two's complement negation mod 2^DATA_W; also yields |x| for negative x.
  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] x,
                                                    input logic              neg);
    return neg ? (~x + DATA_W'(1)) : x;
  endfunction

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[DATA_W-1]),
    .dsr_i     (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    dvd_neg_d = dvd_neg_q;
    dsr_neg_d = dsr_neg_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ready_d   = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start && !bus.annul) begin
          sgn_d     = bus.signed_div;
          dvd_neg_d = bus.dividend[DATA_W-1];
          dsr_neg_d = bus.divisor[DATA_W-1];
          dvd_d     = cond_negate(bus.dividend, bus.signed_div & bus.dividend[DATA_W-1]);
          dsr_d     = cond_negate(bus.divisor, bus.signed_div & bus.divisor[DATA_W-1]);
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = '0;
          state_d   = (bus.divisor == '0) ? DIV_BYZERO : DIV_RUN;
        end
      end

      DIV_BYZERO: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
        end else begin
          hi_d    = '0;
          lo_d    = '0;
          ready_d = 1'b1;
          state_d = DIV_DONE;
        end
      end

      DIV_RUN: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = {quo_q[DATA_W-2:0], step_bit};
          dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          cnt_d = cnt_q + DIV_CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            lo_d    = cond_negate(quo_d, sgn_q & (dvd_neg_q ^ dsr_neg_q));
            hi_d    = cond_negate(step_rem, sgn_q & dvd_neg_q);
            ready_d = 1'b1;
            state_d = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dsr_neg_q <= 1'b0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      dvd_neg_q <= dvd_neg_d;
      dsr_neg_q <= dsr_neg_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_hi = hi_q;
  assign bus.result_lo = lo_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = (state_q != DIV_IDLE);
  // Low in the ready cycle so EX advances while the result is presented.
  assign bus.stall_req = bus.start & ~ready_q & ~bus.annul;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed divides push expected HI/LO into a queue,
// a negedge monitor pops and compares on every ready pulse.
module tb_div_ctrl;

  logic clk;
  logic rst_n;

  div_ctrl_if #(.DATA_W(32)) bus ();

  div_ctrl #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  int          exp_id_q[$];
  logic        prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.ready) begin
      check("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
      if (exp_hi_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0");
      end else begin
        int          id;
        logic [31:0] eh;
        logic [31:0] el;
        id = exp_id_q.pop_front();
        eh = exp_hi_q.pop_front();
        el = exp_lo_q.pop_front();
        check($sformatf("div%0d_lo", id), bus.result_lo, el);
        check($sformatf("div%0d_hi", id), bus.result_hi, eh);
      end
    end
    prev_ready = bus.ready;
  end

  // Issue one divide, push its expectation, check latency and stall_req.
  task automatic do_div(input int id, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_lo,
                        input logic [31:0] e_hi, input int e_lat);
    int   edges;
    logic stall_bad;
    exp_id_q.push_back(id);
    exp_hi_q.push_back(e_hi);
    exp_lo_q.push_back(e_lo);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    #1;
    check($sformatf("div%0d_stall_rise", id), {31'd0, bus.stall_req}, 32'd1);
    edges     = 0;
    stall_bad = 1'b0;
    while (edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.ready) break;
      if (!bus.stall_req) stall_bad = 1'b1;
    end
    if (!bus.ready) begin
      checks++;
      failures++;
      $display("FAIL div%0d_timeout actual=no_ready required=ready", id);
    end else begin
      check($sformatf("div%0d_latency", id), edges - 1, e_lat);
      check($sformatf("div%0d_stall_ready", id), {31'd0, bus.stall_req}, 32'd0);
    end
    check($sformatf("div%0d_stall_hold", id), {31'd0, stall_bad}, 32'd0);
    bus.start = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.annul      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hi", bus.result_hi, 32'd0);
    check("rst_lo", bus.result_lo, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_req}, 32'd0);

    do_div(1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32);
    do_div(2, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
    do_div(3, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 32);
    do_div(4, 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1);
    do_div(5, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32);
    do_div(6, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32);
    do_div(7, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32);

    // Annul 10 iterations into RUN: no ready, previous results kept.
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd1000;
    bus.divisor    = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul_busy_before", {31'd0, bus.busy}, 32'd1);
    check("annul_stall", {31'd0, bus.stall_req}, 32'd0);
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("annul_busy", {31'd0, bus.busy}, 32'd0);
    check("annul_ready", {31'd0, bus.ready}, 32'd0);
    check("annul_keep_lo", bus.result_lo, 32'hFFFF_FFFF);
    check("annul_keep_hi", bus.result_hi, 32'd0);
    repeat (40) @(posedge clk);

    do_div(8, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 32);

    // Synchronous reset at RUN iteration 20.
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("midrst_hi", bus.result_hi, 32'd0);
    check("midrst_lo", bus.result_lo, 32'd0);
    check("midrst_ready", {31'd0, bus.ready}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(posedge clk);

    // Back-to-back: second start raised in the first IDLE cycle after DONE.
    do_div(9, 1'b0, 32'd12, 32'd5, 32'd2, 32'd2, 32);
    do_div(10, 1'b0, 32'd8, 32'd3, 32'd2, 32'd2, 32);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_empty", exp_hi_q.size(), 32'd0);
    check("final_busy", {31'd0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
